// File: rtl/tis_pkg.sv
// Shared TIS-100 corecomplex definitions: word type, port directions and stack depth.
package tis_pkg;

    typedef logic signed [10:0] word_t;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_LEFT  = 2'd1,
        DIR_RIGHT = 2'd2,
        DIR_DOWN  = 2'd3
    } dir_e;

    localparam int STACK_DEPTH = 15;
    localparam int WORD_W      = $bits(word_t);

    function automatic logic [1:0] dir_next(input logic [1:0] d);
        return d + 2'd1;
    endfunction

endpackage

// File: rtl/rr_arb4.sv
// Four-way round-robin arbiter: the first requester at or after ptr_i (wrapping) wins.
module rr_arb4 (
    input  logic [3:0] req_i,
    input  logic [1:0] ptr_i,
    output logic [3:0] gnt_o,
    output logic [1:0] idx_o,
    output logic       valid_o
);

    logic [1:0] cand_s;
    logic       hit_s;
    logic       found_s;

    // Scan upward from the pointer; each slot is visited exactly once.
    always_comb begin
        gnt_o   = 4'b0000;
        found_s = 1'b0;
        cand_s  = ptr_i;
        hit_s   = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cand_s        = ptr_i + 2'(k);
            hit_s         = req_i[cand_s] & ~found_s;
            gnt_o[cand_s] = hit_s;
            found_s       = found_s | hit_s;
        end
        valid_o = found_s;
    end

    // Encode the one-hot grant; with no request the index rests on the pointer.
    always_comb begin
        case (gnt_o)
            4'b0001: idx_o = 2'd0;
            4'b0010: idx_o = 2'd1;
            4'b0100: idx_o = 2'd2;
            4'b1000: idx_o = 2'd3;
            default: idx_o = ptr_i;
        endcase
    end

endmodule

// File: rtl/stack_node_chk.sv
// Protocol checks on the stack node's outbound port: offers never multi-hot, acks only on live offers.
module stack_node_chk (
    input logic       clk_i,
    input logic       rst_i,
    input logic [3:0] write_i,
    input logic [3:0] wready_i
);

    a_write_onehot0: assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(write_i))
        else $error("stack_node: write is multi-hot (%b)", write_i);

    a_wready_live: assert property (@(posedge clk_i) disable iff (rst_i)
                                    (wready_i & ~write_i) == 4'b0000)
        else $error("stack_node: wready %b without matching write %b", wready_i, write_i);

endmodule

// File: rtl/stack_node.sv
// TIS-100 stack memory node: LIFO fed by four reader-side ports, top offered to one neighbour at a time.
// Define STACK_STATUS_EN to add the count and sticky overflow_seen outputs.
module stack_node
    import tis_pkg::*;
#(
    parameter int DEPTH = STACK_DEPTH,
    parameter int WIDTH = WORD_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       rready,
    output logic [3:0]       read,
    input  logic [WIDTH-1:0] in  [0:3],
    output logic [3:0]       write,
    input  logic [3:0]       wready,
    output logic [WIDTH-1:0] out [0:3]
`ifdef STACK_STATUS_EN
    ,
    output logic [4:0]       count,
    output logic             overflow_seen
`endif
);

    localparam int         AW      = $clog2(DEPTH);
    localparam logic [4:0] SP_FULL = 5'(DEPTH);

    logic [WIDTH-1:0] mem_q [0:DEPTH-1];
    logic [4:0]       sp_q, sp_d;
    logic [3:0]       write_q, write_d;
    logic [WIDTH-1:0] top_q, top_d;
    logic [1:0]       push_ptr_q, push_ptr_d;
    logic [1:0]       pop_ptr_q, pop_ptr_d;

    logic             pop_fire_s, push_fire_s, can_push_s, offer_valid_s;
    logic [3:0]       push_req_s, push_gnt_s, offer_req_s, offer_gnt_s;
    logic [1:0]       push_idx_s, offer_ptr_s, offer_idx_s;
    logic [AW-1:0]    wr_idx_s, under_idx_s;
    logic [WIDTH-1:0] push_data_s;

    // A pop completing this cycle frees a slot, so a full stack may still accept one push.
    always_comb begin
        pop_fire_s  = |(write_q & wready);
        can_push_s  = (sp_q < SP_FULL) | pop_fire_s;
        push_req_s  = (can_push_s & ~rst) ? rready : 4'b0000;
        offer_ptr_s = (write_q != 4'b0000) ? dir_next(pop_ptr_q) : pop_ptr_q;
        offer_req_s = (sp_q != 5'd0) ? 4'b1111 : 4'b0000;
    end

    rr_arb4 u_push_arb (
        .req_i   (push_req_s),
        .ptr_i   (push_ptr_q),
        .gnt_o   (push_gnt_s),
        .idx_o   (push_idx_s),
        .valid_o (push_fire_s)
    );

    rr_arb4 u_offer_arb (
        .req_i   (offer_req_s),
        .ptr_i   (offer_ptr_s),
        .gnt_o   (offer_gnt_s),
        .idx_o   (offer_idx_s),
        .valid_o (offer_valid_s)
    );

    // Push+pop in one cycle overwrites the old top in place; sp is unchanged.
    always_comb begin
        push_data_s = in[push_idx_s];
        wr_idx_s    = pop_fire_s ? (sp_q[AW-1:0] - AW'(1)) : sp_q[AW-1:0];
        under_idx_s = sp_q[AW-1:0] - AW'(2);
        sp_d        = sp_q;
        top_d       = top_q;
        push_ptr_d  = push_ptr_q;
        if (push_fire_s) begin
            push_ptr_d = dir_next(push_idx_s);
            top_d      = push_data_s;
            sp_d       = pop_fire_s ? sp_q : (sp_q + 5'd1);
        end else if (pop_fire_s) begin
            sp_d  = sp_q - 5'd1;
            top_d = (sp_q > 5'd1) ? mem_q[under_idx_s] : '0;
        end else begin
            sp_d  = sp_q;
        end

        if (pop_fire_s) begin
            write_d   = 4'b0000;
            pop_ptr_d = dir_next(pop_ptr_q);
        end else begin
            write_d   = offer_valid_s ? offer_gnt_s : 4'b0000;
            pop_ptr_d = offer_idx_s;
        end
    end

    // Stack storage, registered top-of-stack and both round-robin pointers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            sp_q       <= 5'd0;
            write_q    <= 4'b0000;
            top_q      <= '0;
            push_ptr_q <= 2'd0;
            pop_ptr_q  <= 2'd0;
        end else begin
            if (push_fire_s) begin
                mem_q[wr_idx_s] <= push_data_s;
            end
            sp_q       <= sp_d;
            write_q    <= write_d;
            top_q      <= top_d;
            push_ptr_q <= push_ptr_d;
            pop_ptr_q  <= pop_ptr_d;
        end
    end

    assign read  = push_gnt_s;
    assign write = write_q;

    // Every direction carries the same registered top-of-stack.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            out[i] = top_q;
        end
    end

`ifdef STACK_STATUS_EN
    logic ovf_q, ovf_d;

    // Sticky: a writer was held off by a full stack with nothing popping.
    always_comb begin
        ovf_d = ovf_q | ((sp_q == SP_FULL) & (rready != 4'b0000) & ~pop_fire_s);
    end

    // Overflow flag register, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign count         = sp_q;
    assign overflow_seen = ovf_q;
`endif

    stack_node_chk u_chk (
        .clk_i    (clk),
        .rst_i    (rst),
        .write_i  (write_q),
        .wready_i (wready)
    );

endmodule

// File: tb/tb_stack_node.sv
// Directed bench for stack_node: LIFO order, round-robin push, full stall, offer latency, push+pop, reset.
module tb_stack_node;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  rready, read, write, wready;
    logic [10:0] din  [0:3];
    logic [10:0] dout [0:3];
`ifdef STACK_STATUS_EN
    logic [4:0]  count;
    logic        overflow_seen;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    stack_node dut (
        .clk    (clk),
        .rst    (rst),
        .rready (rready),
        .read   (read),
        .in     (din),
        .write  (write),
        .wready (wready),
        .out    (dout)
`ifdef STACK_STATUS_EN
        ,
        .count         (count),
        .overflow_seen (overflow_seen)
`endif
    );

    function automatic logic [10:0] w(input int v);
        return v[10:0];
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst    = 1'b1;
        rready = 4'b0000;
        wready = 4'b0000;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Neighbour d writes v: hold rready until read[d] pulses, then drop it.
    task automatic push_val(input int d, input logic [10:0] v);
        int n = 0;
        @(negedge clk);
        din[d]    = v;
        rready[d] = 1'b1;
        #1;
        while (!read[d] && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        check_eq("push_ack", 32'(read), 32'(4'b0001 << d));
        @(negedge clk);
        rready[d] = 1'b0;
    endtask

    task automatic wait_offer(input int d, input string tag);
        int n = 0;
        @(negedge clk); #1;
        while (!write[d] && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        check_eq(tag, 32'(write[d]), 32'd1);
    endtask

    // Neighbour d reads: wait for the offer, take it, expect the one-cycle gap.
    task automatic pop_from(input int d, input logic [10:0] exp, input string tag);
        wait_offer(d, {tag, "_offer"});
        check_eq(tag, 32'(dout[d]), 32'(exp));
        wready[d] = 1'b1;
        @(negedge clk);
        wready[d] = 1'b0;
        #1;
        check_eq({tag, "_gap"}, 32'(write), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] seen;
        rst    = 1'b1;
        rready = 4'b1111;
        wready = 4'b0000;
        for (int i = 0; i < 4; i++) din[i] = 11'd0;
        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_read", 32'(read), 32'd0);
        check_eq("rst_write", 32'(write), 32'd0);
        check_eq("rst_out", 32'(dout[1]), 32'd0);
        rready = 4'b0000;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("idle_write", 32'(write), 32'd0);

        // LIFO order through one reader on direction 2
        push_val(0, w(3));
        push_val(0, w(5));
        push_val(0, w(-7));
        pop_from(2, w(-7), "t1_pop0");
        pop_from(2, w(5), "t1_pop1");
        pop_from(2, w(3), "t1_pop2");
        repeat (3) @(negedge clk);
        #1;
        check_eq("t1_empty_write", 32'(write), 32'd0);
        check_eq("t1_empty_out", 32'(dout[0]), 32'd0);

        // Push into empty: offer resumes at direction 3, two cycles after the read pulse
        @(negedge clk);
        din[0] = w(123); rready[0] = 1'b1;
        #1;
        check_eq("t4_read", 32'(read), 32'd1);
        @(negedge clk);
        rready[0] = 1'b0;
        #1;
        check_eq("t4_write_early", 32'(write), 32'd0);
        @(negedge clk); #1;
        check_eq("t4_write3", 32'(write), 32'(4'b1000));
        check_eq("t4_value", 32'(dout[3]), 32'(w(123)));
        wready[3] = 1'b1;
        @(negedge clk);
        wready[3] = 1'b0;
        #1;
        check_eq("t4_after", 32'(write), 32'd0);

        // Round-robin push from all four directions
        apply_reset();
        @(negedge clk);
        din[0] = w(10); din[1] = w(20); din[2] = w(30); din[3] = w(40);
        rready = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin
                @(negedge clk);
                rready[k-1] = 1'b0;
            end
            #1;
            check_eq("t2_rr_read", 32'(read), 32'(4'b0001 << k));
        end
        @(negedge clk);
        rready = 4'b0000;
        pop_from(0, w(40), "t2_pop0");
        pop_from(1, w(30), "t2_pop1");
        pop_from(2, w(20), "t2_pop2");
        pop_from(3, w(10), "t2_pop3");

        // Simultaneous pop of 2 and push of 99 on [1,2]
        apply_reset();
        push_val(0, w(1));
        push_val(0, w(2));
        wait_offer(1, "t5_offer");
        check_eq("t5_popped", 32'(dout[1]), 32'(w(2)));
        din[2] = w(99); rready[2] = 1'b1; wready[1] = 1'b1;
        #1;
        check_eq("t5_read", 32'(read), 32'(4'b0100));
        @(negedge clk);
        rready[2] = 1'b0; wready[1] = 1'b0;
        #1;
        check_eq("t5_gap", 32'(write), 32'd0);
        check_eq("t5_top", 32'(dout[0]), 32'(w(99)));
`ifdef STACK_STATUS_EN
        check_eq("t5_count", 32'(count), 32'd2);
`endif
        pop_from(3, w(99), "t5_pop0");
        pop_from(0, w(1), "t5_pop1");
        repeat (3) @(negedge clk);
        #1;
        check_eq("t5_empty", 32'(write), 32'd0);

        // Full stack stalls writers; a pop admits exactly one push
        apply_reset();
        for (int k = 0; k < 15; k++) push_val(0, w(100 + k));
        @(negedge clk);
        din[1] = w(555); rready[1] = 1'b1;
        #1;
        check_eq("t3_full_read", 32'(read), 32'd0);
        repeat (2) @(negedge clk);
        #1;
        check_eq("t3_full_read_held", 32'(read), 32'd0);
`ifdef STACK_STATUS_EN
        check_eq("t3_overflow", 32'(overflow_seen), 32'd1);
        check_eq("t3_count_full", 32'(count), 32'd15);
`endif
        wait_offer(2, "t3_offer");
        check_eq("t3_top", 32'(dout[2]), 32'(w(114)));
        wready[2] = 1'b1;
        #1;
        check_eq("t3_swap_read", 32'(read), 32'(4'b0010));
        @(negedge clk);
        wready[2] = 1'b0; rready[1] = 1'b0;
        #1;
        check_eq("t3_new_top", 32'(dout[0]), 32'(w(555)));
`ifdef STACK_STATUS_EN
        check_eq("t3_count_after", 32'(count), 32'd15);
`endif

        // Reset in the middle of an offer with four entries
        apply_reset();
        for (int k = 1; k <= 4; k++) push_val(0, w(k));
        @(negedge clk); #1;
        check_eq("t6_offer_live", 32'(write != 4'b0000), 32'd1);
        din[0] = w(7); rready[0] = 1'b1;
        #1;
        check_eq("t6_read_pre", 32'(read), 32'd1);
        rst = 1'b1;
        #1;
        check_eq("t6_rst_write", 32'(write), 32'd0);
        check_eq("t6_rst_read", 32'(read), 32'd0);
        check_eq("t6_rst_out", 32'(dout[2]), 32'd0);
        @(negedge clk);
        rready[0] = 1'b0;
        @(negedge clk);
        rst  = 1'b0;
        seen = 4'b0000;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk); #1;
            seen = seen | write;
        end
        check_eq("t6_post_write", 32'(seen), 32'd0);
`ifdef STACK_STATUS_EN
        check_eq("t6_count", 32'(count), 32'd0);
        check_eq("t6_overflow_clr", 32'(overflow_seen), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
